// File: rtl/ifu_fetch_if.sv
// Fetch-stage bundle: redirect input, instruction-memory read channel, decode handshake and perf outputs.
// master = fetch stage, slave = surrounding core/memory.
interface ifu_fetch_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        mem_arvalid;
    logic [31:0] mem_araddr;
    logic        mem_arready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rready;

    logic [31:0] inst;
    logic [31:0] pc;
    logic        fetch_fault;
    logic        IFU_valid;
    logic        IDU_ready;

    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_wait_cnt;

    modport master (
        input  redirect_valid, redirect_pc,
        input  mem_arready, mem_rvalid, mem_rdata, mem_rresp,
        input  IDU_ready,
        output mem_arvalid, mem_araddr, mem_rready,
        output inst, pc, fetch_fault, IFU_valid,
        output perf_fetch_cnt, perf_wait_cnt
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output mem_arready, mem_rvalid, mem_rdata, mem_rresp,
        output IDU_ready,
        input  mem_arvalid, mem_araddr, mem_rready,
        input  inst, pc, fetch_fault, IFU_valid,
        input  perf_fetch_cnt, perf_wait_cnt
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues one read per instruction, hands words to decode.
// Optional performance counters are built when IFU_PERF_EN is defined; otherwise they read as 0.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    ifu_fetch_if.master bus
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

    typedef enum logic [1:0] {REQ, WAIT_R, HOLD} state_t;

    state_t          state_q, state_n;
    logic [XLEN-1:0] pc_q, pc_n;
    logic [XLEN-1:0] inst_q, inst_n;
    logic [XLEN-1:0] pend_q, pend_n;
    logic            fault_q, fault_n;
    logic            discard_q, discard_n;
    logic            arvalid_q, arvalid_n;
    logic            rready_q, rready_n;
    logic            valid_q, valid_n;

    logic            load_c;
    logic [XLEN-1:0] load_pc_c;
    logic            ifu_valid_c;

    // A redirect kills the held instruction in the same cycle so decode never sees it.
    assign ifu_valid_c = valid_q & ~bus.redirect_valid;

    assign bus.mem_arvalid = arvalid_q;
    assign bus.mem_araddr  = pc_q;
    assign bus.mem_rready  = rready_q;
    assign bus.inst        = inst_q;
    assign bus.pc          = pc_q;
    assign bus.fetch_fault = fault_q;
    assign bus.IFU_valid   = ifu_valid_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= REQ;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            pend_q    <= '0;
            fault_q   <= 1'b0;
            discard_q <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_n;
            pc_q      <= pc_n;
            inst_q    <= inst_n;
            pend_q    <= pend_n;
            fault_q   <= fault_n;
            discard_q <= discard_n;
            arvalid_q <= arvalid_n;
            rready_q  <= rready_n;
            valid_q   <= valid_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        pc_n      = pc_q;
        inst_n    = inst_q;
        pend_n    = pend_q;
        fault_n   = fault_q;
        discard_n = discard_q;
        arvalid_n = arvalid_q;
        rready_n  = rready_q;
        valid_n   = valid_q;
        load_c    = 1'b0;
        load_pc_c = pc_q;

        case (state_q)
            REQ: begin
                if (!arvalid_q) begin
                    // First cycle out of reset: start fetching (or honour an early redirect).
                    load_c    = 1'b1;
                    load_pc_c = bus.redirect_valid ? bus.redirect_pc : pc_q;
                end else begin
                    if (bus.redirect_valid) begin
                        discard_n = 1'b1;
                        pend_n    = bus.redirect_pc;
                    end
                    if (bus.mem_arready) begin
                        state_n   = WAIT_R;
                        arvalid_n = 1'b0;
                        rready_n  = 1'b1;
                    end
                end
            end
            WAIT_R: begin
                if (bus.redirect_valid) begin
                    discard_n = 1'b1;
                    pend_n    = bus.redirect_pc;
                end
                if (bus.mem_rvalid) begin
                    rready_n = 1'b0;
                    if (discard_q || bus.redirect_valid) begin
                        discard_n = 1'b0;
                        load_c    = 1'b1;
                        load_pc_c = bus.redirect_valid ? bus.redirect_pc : pend_q;
                    end else begin
                        inst_n  = bus.mem_rdata;
                        fault_n = |bus.mem_rresp;
                        valid_n = 1'b1;
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    load_c    = 1'b1;
                    load_pc_c = bus.redirect_pc;
                end else if (ifu_valid_c && bus.IDU_ready) begin
                    load_c    = 1'b1;
                    load_pc_c = pc_q + PC_STEP;
                end
            end
            default: begin
                state_n   = REQ;
                arvalid_n = 1'b0;
                rready_n  = 1'b0;
                valid_n   = 1'b0;
            end
        endcase

        // New PC: aligned targets fetch next cycle, misaligned ones fault without touching the bus.
        if (load_c) begin
            pc_n     = load_pc_c;
            rready_n = 1'b0;
            if (load_pc_c[1:0] != 2'b00) begin
                state_n   = HOLD;
                inst_n    = NOP_INST;
                fault_n   = 1'b1;
                valid_n   = 1'b1;
                arvalid_n = 1'b0;
            end else begin
                state_n   = REQ;
                valid_n   = 1'b0;
                arvalid_n = 1'b1;
            end
        end
    end

`ifdef IFU_PERF_EN
    logic [XLEN-1:0] fetch_cnt_q;
    logic [XLEN-1:0] wait_cnt_q;

    // Wait cycles are those with a bus transaction in flight (address or data phase).
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            if (ifu_valid_c && bus.IDU_ready) begin
                fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
            end
            if ((state_q == REQ && arvalid_q) || state_q == WAIT_R) begin
                wait_cnt_q <= wait_cnt_q + XLEN'(1);
            end
        end
    end

    assign bus.perf_fetch_cnt = fetch_cnt_q;
    assign bus.perf_wait_cnt  = wait_cnt_q;
`else
    assign bus.perf_fetch_cnt = '0;
    assign bus.perf_wait_cnt  = '0;
`endif

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch stage of the NPC core, directly upstream of the instruction decode stage. It owns the architectural fetch PC and issues one read per instruction on an AXI-lite-style read channel. It presents the returned word plus its PC to decode over an `IFU_valid`/`IDU_ready` handshake. It advances sequentially (`pc+4`) and is redirected by the execute stage on taken branches, jumps, `ecall` and `mret`.

## Interface
Parameters:
- `RESET_PC`, default `32'h8000_0000`: first fetch address after reset.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `redirect_valid`, in, 1: execute stage requests a fetch from `redirect_pc`.
- `redirect_pc`, in, 32: redirect target.
- `mem_arvalid`, out, 1: read address valid.
- `mem_araddr`, out, 32: read address, equal to `pc`.
- `mem_arready`, in, 1: memory accepts the address.
- `mem_rvalid`, in, 1: read data valid.
- `mem_rdata`, in, 32: instruction word.
- `mem_rresp`, in, 2: nonzero means access error.
- `mem_rready`, out, 1: fetch ready for data.
- `inst`, out, 32: instruction word to decode.
- `pc`, out, 32: PC of `inst` (and of the outstanding request).
- `fetch_fault`, out, 1: `inst` is invalid because of a bus error or a misaligned target.
- `IFU_valid`, out, 1: `inst`/`pc` valid for decode.
- `IDU_ready`, in, 1: decode accepts.
- `perf_fetch_cnt`, out, 32: instructions handed to decode.
- `perf_wait_cnt`, out, 32: cycles spent in REQ or WAIT_R.

## Operation
FSM states: REQ, WAIT_R, HOLD.
- **REQ**
  - `mem_arvalid`=1 and `mem_araddr`=`pc`.
  - On `arvalid & arready`, go to WAIT_R.
  - Once `mem_arvalid` is high, `mem_araddr` is held stable until the handshake, per AXI rules.
- **WAIT_R**
  - `mem_rready`=1.
  - On `rvalid`: if the `discard` flag is set, drop the data, load `pc` from `pend_pc`, clear `discard`, and go to REQ.
  - Otherwise latch `inst`=`mem_rdata` and `fetch_fault`=(`rresp`!=0), then go to HOLD.
- **HOLD**
  - `IFU_valid` = `valid_r & ~redirect_valid`.
  - On `IFU_valid & IDU_ready`: `pc` <= `pc+4` (mod 2^32, wraps at `32'hFFFF_FFFC` to 0), go to REQ.

Redirect:
- **In HOLD:** the held instruction is dropped. `redirect_valid` masks `IFU_valid` in the same cycle, so no handshake occurs. Next: `pc` <= `redirect_pc`, state REQ.
- **In REQ before the AR handshake:** `pc` and address are not changed. The block records `pend_pc`=`redirect_pc` and sets `discard`=1. The request completes and its response is dropped. A redirect in the same cycle as the AR handshake behaves identically.
- **In WAIT_R:** set `discard` and `pend_pc`. A redirect in the same cycle as `rvalid` also discards that response.
- **Multiple redirects before resolution:** the last one wins for `pend_pc`.
- **Misaligned target:** if the effective new PC has `[1:0]` != 0, no bus request is made. The block goes to HOLD with `inst`=`32'h0000_0013` (nop) and `fetch_fault`=1, while `pc` holds the misaligned value.

## Timing
Reset values:
- State REQ, `pc`=`RESET_PC`.
- `IFU_valid`=0, `mem_arvalid`=0 during the reset cycle.
- `mem_rready`=0, `inst`=0, `fetch_fault`=0.
- `discard`=0, perf counters 0.
- `mem_arvalid` rises in the first cycle after `rst` falls.

Handshake and latency:
- Zero-wait memory gives 3 cycles per instruction: AR handshake in cycle 0, R in cycle 1, HOLD with `IDU_ready` in cycle 2, next REQ in cycle 3.
- `IFU_valid` rises the cycle after `rvalid` is accepted.
- `IFU_valid` stays high, with `inst`/`pc` stable, until accepted or redirected.
- `mem_rready` is only high in WAIT_R.
- The only combinational input-to-output path is `redirect_valid` to `IFU_valid`.

Reset mid-operation: the FSM returns to REQ at `RESET_PC` and any outstanding response is abandoned. The memory shares `rst`.

## Configuration
`IFU_PERF_EN`:
- **Defined:** `perf_fetch_cnt` increments on each `IFU_valid & IDU_ready`. `perf_wait_cnt` increments on every cycle in REQ or WAIT_R. Both are 32-bit, wrap to 0, and are cleared by `rst`.
- **Undefined:** no counter flops; both outputs are tied to 0.

## Test plan
- Reset release, zero-wait memory returning `32'h0000_0093`, `IDU_ready`=1: first `araddr`=`32'h8000_0000` at cycle 1. `IFU_valid` at cycle 3 with `pc`=`32'h8000_0000`. Next `araddr`=`32'h8000_0004`.
- `IDU_ready`=0 for 5 cycles in HOLD: `IFU_valid`, `inst` and `pc` are stable, no new AR is issued, and `perf_wait_cnt` does not increment.
- Redirect to `32'h8000_0100` while `arready`=0 in REQ: the address stays at the old PC until accepted, the response is dropped, the next AR goes to `32'h8000_0100`, and no `IFU_valid` is produced for the old PC.
- Redirect to `32'h8000_0040` in HOLD with `IDU_ready`=1 in the same cycle: `IFU_valid`=0 that cycle, and the next fetch goes to `32'h8000_0040`.
- `rresp`=`2'b10`: `IFU_valid` with `fetch_fault`=1. Redirect to `32'h8000_0002`: no AR, HOLD with `inst`=`32'h0000_0013` and `fetch_fault`=1.
- With `IFU_PERF_EN` defined, 10 accepted instructions on zero-wait memory give `perf_fetch_cnt`=10 and `perf_wait_cnt`=20. Undefined, both stay 0.
